// File: rtl/id_ex_skid_reg_pkg.sv
// Shared definitions for the decode-to-execute skid buffer feeding Mux_E.
// State encoding is {skid_valid, main_valid}; payload bundle is {S_E, E1, E0}.
package id_ex_skid_reg_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int PAYLOAD_W = 2 * WIDTH_DEF + 1;

  function automatic int payload_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/id_ex_skid_reg_pipe_payload_reg.sv
// Load-enabled payload register with asynchronous active-high clear.
module pipe_payload_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// Two-entry valid/ready skid buffer between decode and the execute operand mux,
// with a saturating counter of execute back-pressure cycles.
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_E0,
  input  logic [WIDTH-1:0] In_E1,
  input  logic             In_S_E,
  input  logic             Flush,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_E0,
  output logic [WIDTH-1:0] Out_E1,
  output logic             Out_S_E,
  output logic [CNT_W-1:0] Stall_Cnt
);

  localparam int PW = payload_w(WIDTH);

  logic [1:0]       state_p1;
  logic [1:0]       state_nxt;
  logic             in_ready_p1;
  logic [CNT_W-1:0] stall_cnt_p1;
  logic [PW-1:0]    in_pay_p0;
  logic [PW-1:0]    main_d;
  logic [PW-1:0]    main_pay_p1;
  logic [PW-1:0]    skid_pay_p1;
  logic             accept;
  logic             consume;
  logic             main_ld;
  logic             skid_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_pay_p0 = {In_S_E, In_E1, In_E0};

  // p0 -> p1: next-state and capture selection
  always_comb begin
    accept    = In_Valid & in_ready_p1;
    consume   = state_p1[0] & Out_Ready;
    state_nxt = state_p1;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = in_pay_p0;
    if (Flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          if (accept) begin
            main_ld   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_ld = 1'b1;
          end else if (consume) begin
            state_nxt = ST_EMPTY;
          end else if (accept) begin
            skid_ld   = 1'b1;
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_ld   = 1'b1;
            main_d    = skid_pay_p1;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // In_Ready is registered from the next skid state so Out_Ready never reaches it combinationally
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_p1     <= ST_EMPTY;
      in_ready_p1  <= 1'b1;
      stall_cnt_p1 <= '0;
    end else begin
      state_p1    <= state_nxt;
      in_ready_p1 <= ~state_nxt[1];
      if (state_p1[0] && !Out_Ready) begin
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      end
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clk (Clk),
    .rst (Reset),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_pay_p1)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk (Clk),
    .rst (Reset),
    .ld  (skid_ld),
    .d   (in_pay_p0),
    .q   (skid_pay_p1)
  );

  assign In_Ready                  = in_ready_p1;
  assign Out_Valid                 = state_p1[0];
  assign {Out_S_E, Out_E1, Out_E0} = main_pay_p1;
  assign Stall_Cnt                 = stall_cnt_p1;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: queue-level reference model with per-cycle compare,
// plus directed scenarios carrying hand-computed expectations.
module tb_id_ex_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_e0 = '0;
  logic [31:0] in_e1 = '0;
  logic        in_s_e = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_e0;
  logic [31:0] out_e1;
  logic        out_s_e;
  logic [7:0]  stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_skid_reg #(.WIDTH(32), .CNT_W(8)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_E0     (in_e0),
    .In_E1     (in_e1),
    .In_S_E    (in_s_e),
    .Flush     (flush),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_E0    (out_e0),
    .Out_E1    (out_e1),
    .Out_S_E   (out_s_e),
    .Stall_Cnt (stall_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held sets, the last set seen at the head, and a stall count
  logic [64:0] q[$];
  logic [64:0] last_main = '0;
  int          m_stall = 0;

  always @(posedge clk or posedge rst) begin
    bit acc;
    bit con;
    if (rst) begin
      q.delete();
      last_main = '0;
      m_stall   = 0;
    end else begin
      acc = in_valid && (q.size() < 2);
      con = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready && m_stall < 255) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back({in_s_e, in_e1, in_e0});
      end
      if (q.size() > 0) last_main = q[0];
    end
  end

  always @(negedge clk) begin
    logic [64:0] exp_pay;
    exp_pay = (q.size() > 0) ? q[0] : last_main;
    chk("m_out_valid", out_valid, q.size() > 0);
    chk("m_in_ready", in_ready, q.size() < 2);
    chk("m_payload", {out_s_e, out_e1, out_e0}, exp_pay);
    chk("m_stall_cnt", stall_cnt, m_stall);
  end

  task automatic drive(input logic v, input logic [31:0] e0, input logic [31:0] e1,
                       input logic s, input logic ordy, input logic fl);
    in_valid  = v;
    in_e0     = e0;
    in_e1     = e1;
    in_s_e    = s;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r0;
    logic pend;
    // Reset asserted mid-cycle, checked before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_e0", out_e0, 32'h0);
    chk("rst_stall", stall_cnt, 8'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Streaming, one set per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h80 + i, 32'h8000 + i, ~i[0], 1'b1, 1'b0);
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_e0", out_e0, 32'h80 + i);
      if (i == 0) begin
        chk("stream_first_e1", out_e1, 32'h8000);
        chk("stream_first_s", out_s_e, 1'b1);
      end
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_stall", stall_cnt, 8'd0);

    // Back-pressure: A and B fill the buffer, C waits
    drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_a_valid", out_valid, 1'b1);
    chk("bp_a_ready", in_ready, 1'b1);
    drive(1'b1, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
    step();
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head_a", out_e0, 32'd1);
    drive(1'b1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("bp_still_full", in_ready, 1'b0);
    chk("bp_stall3", stall_cnt, 8'd3);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_e0, 32'd3);
    chk("bp_head_b_s", out_s_e, 1'b1);
    chk("bp_ready_back", in_ready, 1'b1);
    step();
    chk("bp_head_c", out_e0, 32'd5);
    chk("bp_head_c_e1", out_e1, 32'd6);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_stall_final", stall_cnt, 8'd3);

    // Flush beats a simultaneous accept
    drive(1'b1, 32'd10, 32'd100, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd11, 32'd110, 1'b1, 1'b0, 1'b0);
    step();
    chk("fl_full", in_ready, 1'b0);
    chk("fl_stall_before", stall_cnt, 8'd4);
    drive(1'b1, 32'hD, 32'hD0, 1'b1, 1'b1, 1'b1);
    step();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    chk("fl_stall_kept", stall_cnt, 8'd4);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("fl_no_d", out_valid, 1'b0);
    chk("fl_data_held", out_e0, 32'd10);

    // Counter saturation
    drive(1'b1, 32'h55, 32'h550, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (300) step();
    chk("sat_255", stall_cnt, 8'd255);
    step();
    chk("sat_hold", stall_cnt, 8'd255);

    // Asynchronous reset while FULL
    drive(1'b1, 32'h66, 32'h660, 1'b1, 1'b0, 1'b0);
    step();
    chk("rm_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rm_valid", out_valid, 1'b0);
    chk("rm_ready", in_ready, 1'b1);
    chk("rm_e0", out_e0, 32'h0);
    chk("rm_stall", stall_cnt, 8'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 32'h77, 32'h7700, 1'b1, 1'b1, 1'b0);
    step();
    chk("rm_first_valid", out_valid, 1'b1);
    chk("rm_first_e0", out_e0, 32'h77);
    in_valid = 1'b0;
    step();

    // Random handshake; the per-cycle model compare acts as the scoreboard
    pend = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_e0    = $urandom;
        in_e1    = $urandom;
        in_s_e   = $urandom_range(0, 1);
      end
      flush = ($urandom_range(0, 99) < 5);
      if (c % 50 == 0) begin
        r0 = in_ready;
        out_ready = ~out_ready;
        #1;
        chk("rnd_ready_indep", in_ready, r0);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      r0 = in_ready;
      step();
      pend = in_valid && !r0;
    end

    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
